mf_disp_intf_vga_scaler: RTL and testbench
==========================================

Name: mf_disp_intf_vga_scaler

Overview:
Next-generation VGA display interface. It generates VGA timing from parameters and scales a SRC_W x SRC_H framebuffer by an integer factor of 1 to 4. The scaled image is centred in the active area, with a programmable border colour. It compensates a parametrised framebuffer read latency, provides three selectable test patterns, and keeps the double-buffer frame-select handshake. It sits between the framebuffer read port and the VGA pins, clocked by the pixel clock.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, h front porch cycles
H_SYNC, 96, h sync cycles
H_BACK, 48, h back porch cycles
V_ACTIVE, 480, visible lines
V_FRONT, 10, v front porch lines
V_SYNC, 2, v sync lines
V_BACK, 33, v back porch lines
SRC_W, 320, framebuffer width in pixels
SRC_H, 200, framebuffer height in lines
ADDR_W, 16, framebuffer address width
COLOR_W, 6, framebuffer bits per channel
OUT_W, 4, VGA DAC bits per channel (OUT_W <= COLOR_W)
RD_LAT, 1, framebuffer read latency in cycles (1..4)

Ports:
vga_clk  in  1  pixel clock
resetn  in  1  async active-low reset
intf_mode_enabled  in  1  interface enable
intf_mode_scale  in  2  scale factor minus 1 (0 = x1 .. 3 = x4)
intf_mode_test  in  2  0 = off, 1 = RGB bands, 2 = checker, 3 = gradient
intf_border_rgb  in  3*OUT_W  border colour {r,g,b}
intf_frame_switch  in  1  request buffer swap at the next frame end
intf_frame_sel  out  1  selected framebuffer
intf_frame_done  out  1  one-cycle pulse on the last cycle of each frame
intf_pix_rd_vld  out  1  framebuffer read strobe
intf_pix_rd_addr  out  ADDR_W  framebuffer read address
intf_pix_rd_rdata/gdata/bdata  in  COLOR_W each  read data, valid RD_LAT cycles after the strobe
VGA_hsync, VGA_vsync  out  1 each  active-low syncs
VGA_red/green/blue  out  OUT_W each  colour

Behaviour:
- Reset values: all outputs 0, except VGA_hsync = VGA_vsync = 1. Counters 0, pending flag 0.
- Timing counters:
  - h_cnt runs 0..HT-1, where HT = sum of the H_* parameters.
  - v_cnt runs 0..VT-1, where VT = sum of the V_* parameters; v_cnt increments when h_cnt wraps.
  - The first enabled cycle has h_cnt = 0 and v_cnt = 0.
  - Frame end is h_cnt = HT-1 and v_cnt = VT-1.
- Disabled (intf_mode_enabled = 0): counters held at 0, rd_vld = 0, syncs = 1, rgb = 0, frame_done = 0.
- Mode latching: scale and test mode are latched at frame end, or continuously while disabled. Mid-frame changes have no effect until the next frame.
- Scaling window, with S = latched scale + 1:
  - SW = min(SRC_W*S, H_ACTIVE) and SH = min(SRC_H*S, V_ACTIVE).
  - xoff = (H_ACTIVE-SW)/2 and yoff = (V_ACTIVE-SH)/2, rounded down.
  - The window is xoff <= h_cnt < xoff+SW and yoff <= v_cnt < yoff+SH. Anything else in the active area is border; anything outside the active area is blanking.
- Address generation (no dividers):
  - x_sub counts 0..S-1; src_x increments when x_sub wraps. Both reset to 0 at each window line start.
  - y_sub and row_base work the same way per line: row_base += SRC_W when y_sub wraps. Both reset at frame start.
  - addr = row_base + src_x, truncated to ADDR_W.
- Read strobe: rd_vld = window & (test mode off), in the same cycle as the counters.
- Pipeline alignment:
  - Window, border, blank, sync flags, src_x/src_y and the test-mode select are delayed RD_LAT cycles, then all outputs are registered.
  - Pins therefore lag the counters by RD_LAT+1 cycles for both sync and colour.
- Colour selection:
  - blank -> 0.
  - border -> intf_border_rgb.
  - test mode off -> rdata[COLOR_W-1 -: OUT_W] per channel.
  - bands: src_y < SRC_H/3 red full-scale; < 2*SRC_H/3 green; else blue.
  - checker: white if src_x[3]^src_y[3], else black.
  - gradient: r = src_x[OUT_W-1:0], g = src_y[OUT_W-1:0], b = 0.
- Syncs: hsync low for H_ACTIVE+H_FRONT <= h_cnt < +H_SYNC; vsync low over the equivalent v_cnt range.
- Frame switch:
  - intf_frame_switch sets the pending flag.
  - At frame end with pending = 1 (a switch arriving in that same cycle counts), intf_frame_sel toggles and pending clears.
  - While disabled, a pending switch toggles immediately.
  - intf_frame_done pulses at every frame end, registered, so it is seen one cycle later.
- Reset mid-frame: everything returns to reset values immediately; the in-flight pipeline is discarded.

Test Plan:
- Defaults, RD_LAT=1, scale x1, enable at cycle 0 -> first rd_vld at h_cnt=160, v_cnt=140 with addr 0. VGA_hsync low over cycles 658..753. Border visible at pins on line 0.
- Scale x2 -> window 640x400 with yoff=40. Lines 40 and 41 both start at addr 0; line 42 starts at addr 320; each address is held for 2 cycles. Last address in the frame is 63999.
- Scale x3 -> clipped: xoff=0 and yoff=0. The last src_x on a line is 213 (640/3, rounded down). The last row fetched is 159.
- RD_LAT=3 with a framebuffer model returning addr[5:0] as data -> pin colour equals addr[5:2], exactly 4 cycles after the strobe. Sync edges also shift by 4.
- Frame switch pulsed mid-frame, then again coincident with frame end -> exactly one toggle per frame end. A switch issued while disabled toggles on the next cycle.
- Test mode bands, switched to checker mid-frame -> bands persist until frame end. Checker starts on the next frame with rd_vld = 0 throughout.

Source files
------------

// File: rtl/mf_disp_intf_vga_scaler.sv
// -----------------------------------------------------------------------------
// mf_disp_intf_vga_scaler
//
// VGA display interface with integer upscaling (x1..x4) of a SRC_W x SRC_H
// framebuffer. The scaled image is centred in the active area and surrounded
// by a programmable border colour. A delay line of RD_LAT cycles keeps the
// sync/colour control aligned with framebuffer read data. It also provides
// three built-in test patterns and the double-buffer frame-select handshake.
//
// Ports
//   vga_clk, resetn           pixel clock, async active-low reset
//   intf_mode_enabled         run the timing generator (0 = idle, counters held)
//   intf_mode_scale           scale factor minus one, latched per frame
//   intf_mode_test            0 off, 1 RGB bands, 2 checker, 3 gradient
//   intf_border_rgb           {r,g,b} border colour, OUT_W bits per channel
//   intf_frame_switch         request a buffer swap at the next frame end
//   intf_frame_sel            currently selected framebuffer
//   intf_frame_done           registered pulse for the last cycle of each frame
//   intf_pix_rd_vld/addr      framebuffer read strobe and address
//   intf_pix_rd_r/g/bdata     read data, valid RD_LAT cycles after the strobe
//   VGA_hsync, VGA_vsync      active-low syncs
//   VGA_red/green/blue        DAC colour outputs
// -----------------------------------------------------------------------------
module mf_disp_intf_vga_scaler #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int SRC_W    = 320,
    parameter int SRC_H    = 200,
    parameter int ADDR_W   = 16,
    parameter int COLOR_W  = 6,
    parameter int OUT_W    = 4,
    parameter int RD_LAT   = 1
) (
    input  logic                 vga_clk,
    input  logic                 resetn,
    input  logic                 intf_mode_enabled,
    input  logic [1:0]           intf_mode_scale,
    input  logic [1:0]           intf_mode_test,
    input  logic [3*OUT_W-1:0]   intf_border_rgb,
    input  logic                 intf_frame_switch,
    output logic                 intf_frame_sel,
    output logic                 intf_frame_done,
    output logic                 intf_pix_rd_vld,
    output logic [ADDR_W-1:0]    intf_pix_rd_addr,
    input  logic [COLOR_W-1:0]   intf_pix_rd_rdata,
    input  logic [COLOR_W-1:0]   intf_pix_rd_gdata,
    input  logic [COLOR_W-1:0]   intf_pix_rd_bdata,
    output logic                 VGA_hsync,
    output logic                 VGA_vsync,
    output logic [OUT_W-1:0]     VGA_red,
    output logic [OUT_W-1:0]     VGA_green,
    output logic [OUT_W-1:0]     VGA_blue
);

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Scaled extent clipped to the active area.
    function automatic int fit(input int src, input int s, input int act);
        return (src * s < act) ? src * s : act;
    endfunction

    localparam int HT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int VT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);
    localparam int XW = max3($clog2(SRC_W), 4, OUT_W);
    localparam int YW = max3($clog2(SRC_H), 4, OUT_W);

    localparam logic [HW-1:0] H_LAST   = HW'(HT - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(VT - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [YW-1:0] BAND_1   = YW'(SRC_H / 3);
    localparam logic [YW-1:0] BAND_2   = YW'(2 * SRC_H / 3);

    // Window bounds per scale setting, fully resolved at elaboration so the
    // datapath is a 4-entry constant lookup.
    localparam int X_LO [4] = '{(H_ACTIVE - fit(SRC_W, 1, H_ACTIVE)) / 2,
                                (H_ACTIVE - fit(SRC_W, 2, H_ACTIVE)) / 2,
                                (H_ACTIVE - fit(SRC_W, 3, H_ACTIVE)) / 2,
                                (H_ACTIVE - fit(SRC_W, 4, H_ACTIVE)) / 2};
    localparam int Y_LO [4] = '{(V_ACTIVE - fit(SRC_H, 1, V_ACTIVE)) / 2,
                                (V_ACTIVE - fit(SRC_H, 2, V_ACTIVE)) / 2,
                                (V_ACTIVE - fit(SRC_H, 3, V_ACTIVE)) / 2,
                                (V_ACTIVE - fit(SRC_H, 4, V_ACTIVE)) / 2};
    localparam int X_HI [4] = '{X_LO[0] + fit(SRC_W, 1, H_ACTIVE),
                                X_LO[1] + fit(SRC_W, 2, H_ACTIVE),
                                X_LO[2] + fit(SRC_W, 3, H_ACTIVE),
                                X_LO[3] + fit(SRC_W, 4, H_ACTIVE)};
    localparam int Y_HI [4] = '{Y_LO[0] + fit(SRC_H, 1, V_ACTIVE),
                                Y_LO[1] + fit(SRC_H, 2, V_ACTIVE),
                                Y_LO[2] + fit(SRC_H, 3, V_ACTIVE),
                                Y_LO[3] + fit(SRC_H, 4, V_ACTIVE)};

    typedef enum logic [1:0] {
        TEST_OFF      = 2'd0,
        TEST_BANDS    = 2'd1,
        TEST_CHECKER  = 2'd2,
        TEST_GRADIENT = 2'd3
    } test_e;

    // Per-pixel control that must travel alongside the framebuffer read.
    typedef struct packed {
        logic          window;
        logic          border;
        logic          blank;
        logic          hsync;
        logic          vsync;
        logic [XW-1:0] src_x;
        logic [YW-1:0] src_y;
        test_e         test;
    } pix_ctl_t;

    localparam pix_ctl_t CTL_IDLE = '{window: 1'b0, border: 1'b0, blank: 1'b1,
                                      hsync: 1'b1, vsync: 1'b1, src_x: '0,
                                      src_y: '0, test: TEST_OFF};

    logic              en;
    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic              frame_end;
    logic              line_end;
    logic [1:0]        scale_q;
    test_e             test_q;
    logic [HW-1:0]     x_lo, x_hi;
    logic [VW-1:0]     y_lo, y_hi;
    logic              in_cols, in_rows, active, window;
    logic [1:0]        x_sub, y_sub;
    logic [XW-1:0]     src_x;
    logic [YW-1:0]     src_y;
    logic [ADDR_W-1:0] row_base;
    logic              pending;
    pix_ctl_t          ctl_now, ctl_out;
    pix_ctl_t          ctl_pipe [RD_LAT];
    logic [3*OUT_W-1:0] rgb_next;

    assign en        = intf_mode_enabled;
    assign line_end  = (h_cnt == H_LAST);
    assign frame_end = en && line_end && (v_cnt == V_LAST);

    // ------------------------------------------------------------------ timing
    always_ff @(posedge vga_clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of process order.
        if (!resetn) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Mode is frozen for the whole frame; tracks the inputs while idle.
    always_ff @(posedge vga_clk or negedge resetn) begin
        if (!resetn) begin
            scale_q <= 2'd0;
            test_q  <= TEST_OFF;
        end else if (!en || frame_end) begin
            scale_q <= intf_mode_scale;
            test_q  <= test_e'(intf_mode_test);
        end
    end

    // ------------------------------------------------------------------ window
    always_comb begin
        x_lo    = HW'(X_LO[scale_q]);
        x_hi    = HW'(X_HI[scale_q]);
        y_lo    = VW'(Y_LO[scale_q]);
        y_hi    = VW'(Y_HI[scale_q]);
        in_cols = (h_cnt >= x_lo) && (h_cnt < x_hi);
        in_rows = (v_cnt >= y_lo) && (v_cnt < y_hi);
        active  = en && (h_cnt < H_ACT) && (v_cnt < V_ACT);
        window  = en && in_cols && in_rows;
    end

    // Horizontal source stepping: each source pixel is held for S cycles.
    // Cleared outside the window so every window line starts at column 0.
    always_ff @(posedge vga_clk or negedge resetn) begin
        if (!resetn) begin
            x_sub <= 2'd0;
            src_x <= '0;
        end else if (!window) begin
            x_sub <= 2'd0;
            src_x <= '0;
        end else if (x_sub == scale_q) begin
            x_sub <= 2'd0;
            src_x <= src_x + 1'b1;
        end else begin
            x_sub <= x_sub + 1'b1;
        end
    end

    // Vertical source stepping, advanced at the end of each window row.
    always_ff @(posedge vga_clk or negedge resetn) begin
        if (!resetn) begin
            y_sub    <= 2'd0;
            src_y    <= '0;
            row_base <= '0;
        end else if (!en || frame_end) begin
            y_sub    <= 2'd0;
            src_y    <= '0;
            row_base <= '0;
        end else if (line_end && in_rows) begin
            if (y_sub == scale_q) begin
                y_sub    <= 2'd0;
                src_y    <= src_y + 1'b1;
                row_base <= row_base + ADDR_W'(SRC_W);
            end else begin
                y_sub <= y_sub + 1'b1;
            end
        end
    end

    assign intf_pix_rd_vld  = window && (test_q == TEST_OFF);
    assign intf_pix_rd_addr = row_base + ADDR_W'(src_x);

    // ------------------------------------------------------- latency alignment
    always_comb begin
        ctl_now        = CTL_IDLE;
        ctl_now.window = window;
        ctl_now.border = active && !window;
        ctl_now.blank  = !active;
        ctl_now.hsync  = !(en && (h_cnt >= HS_START) && (h_cnt < HS_END));
        ctl_now.vsync  = !(en && (v_cnt >= VS_START) && (v_cnt < VS_END));
        ctl_now.src_x  = src_x;
        ctl_now.src_y  = src_y;
        ctl_now.test   = test_q;
    end

    always_ff @(posedge vga_clk or negedge resetn) begin
        // NOTE: the delay line is reset to the idle pixel so that a reset
        // mid-frame discards in-flight control instead of leaking it to pins.
        if (!resetn) begin
            for (int i = 0; i < RD_LAT; i++) ctl_pipe[i] <= CTL_IDLE;
        end else begin
            ctl_pipe[0] <= ctl_now;
            for (int i = 1; i < RD_LAT; i++) ctl_pipe[i] <= ctl_pipe[i-1];
        end
    end

    assign ctl_out = ctl_pipe[RD_LAT-1];

    // ------------------------------------------------------------ colour select
    always_comb begin
        // NOTE: default first so every path assigns rgb_next and no latch forms.
        rgb_next = '0;
        if (ctl_out.blank) begin
            rgb_next = '0;
        end else if (ctl_out.border) begin
            rgb_next = intf_border_rgb;
        end else if (ctl_out.window) begin
            unique case (ctl_out.test)
                TEST_OFF: rgb_next = {intf_pix_rd_rdata[COLOR_W-1 -: OUT_W],
                                      intf_pix_rd_gdata[COLOR_W-1 -: OUT_W],
                                      intf_pix_rd_bdata[COLOR_W-1 -: OUT_W]};
                TEST_BANDS: begin
                    if (ctl_out.src_y < BAND_1)
                        rgb_next = {{OUT_W{1'b1}}, {OUT_W{1'b0}}, {OUT_W{1'b0}}};
                    else if (ctl_out.src_y < BAND_2)
                        rgb_next = {{OUT_W{1'b0}}, {OUT_W{1'b1}}, {OUT_W{1'b0}}};
                    else
                        rgb_next = {{OUT_W{1'b0}}, {OUT_W{1'b0}}, {OUT_W{1'b1}}};
                end
                TEST_CHECKER:
                    rgb_next = (ctl_out.src_x[3] ^ ctl_out.src_y[3]) ? '1 : '0;
                TEST_GRADIENT:
                    rgb_next = {ctl_out.src_x[OUT_W-1:0], ctl_out.src_y[OUT_W-1:0],
                                {OUT_W{1'b0}}};
            endcase
        end
    end

    always_ff @(posedge vga_clk or negedge resetn) begin
        if (!resetn) begin
            VGA_hsync <= 1'b1;
            VGA_vsync <= 1'b1;
            VGA_red   <= '0;
            VGA_green <= '0;
            VGA_blue  <= '0;
        end else begin
            VGA_hsync <= ctl_out.hsync;
            VGA_vsync <= ctl_out.vsync;
            {VGA_red, VGA_green, VGA_blue} <= rgb_next;
        end
    end

    // -------------------------------------------------- frame select handshake
    // A request in the frame-end cycle itself is honoured without waiting for
    // the pending flag; while idle there is no frame end, so swap at once.
    always_ff @(posedge vga_clk or negedge resetn) begin
        if (!resetn) begin
            pending         <= 1'b0;
            intf_frame_sel  <= 1'b0;
            intf_frame_done <= 1'b0;
        end else begin
            intf_frame_done <= frame_end;
            if ((!en || frame_end) && (pending || intf_frame_switch)) begin
                intf_frame_sel <= !intf_frame_sel;
                pending        <= 1'b0;
            end else if (intf_frame_switch) begin
                pending <= 1'b1;
            end
        end
    end

    // Only the top OUT_W bits of each read channel drive the DAC.
    if (COLOR_W > OUT_W) begin : g_lsb_sink
        logic unused_lsbs;
        assign unused_lsbs = ^{intf_pix_rd_rdata[COLOR_W-OUT_W-1:0],
                               intf_pix_rd_gdata[COLOR_W-OUT_W-1:0],
                               intf_pix_rd_bdata[COLOR_W-OUT_W-1:0]};
    end

endmodule

// File: tb/tb_mf_disp_intf_vga_scaler.sv
// -----------------------------------------------------------------------------
// Bench for mf_disp_intf_vga_scaler with a shrunken timing (40x28 total,
// 32x24 active, 16x10 source) so several frames fit in a short run. A
// behavioural reference computes the expected read strobe/address by
// division and pushes the expected pin state into a queue; entries are
// popped and compared RD_LAT+1 cycles later when the DUT presents them.
// -----------------------------------------------------------------------------
module tb_mf_disp_intf_vga_scaler;

    localparam int H_ACTIVE = 32, H_FRONT = 2, H_SYNC = 4, H_BACK = 2;
    localparam int V_ACTIVE = 24, V_FRONT = 1, V_SYNC = 2, V_BACK = 1;
    localparam int SRC_W = 16, SRC_H = 10, ADDR_W = 8;
    localparam int COLOR_W = 6, OUT_W = 4, RD_LAT = 3;
    localparam int HT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int VT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int FT = HT * VT;
    localparam logic [13:0] PINS_IDLE = 14'h3000;

    logic                vga_clk;
    logic                resetn;
    logic                intf_mode_enabled;
    logic [1:0]          intf_mode_scale;
    logic [1:0]          intf_mode_test;
    logic [3*OUT_W-1:0]  intf_border_rgb;
    logic                intf_frame_switch;
    logic                intf_frame_sel;
    logic                intf_frame_done;
    logic                intf_pix_rd_vld;
    logic [ADDR_W-1:0]   intf_pix_rd_addr;
    logic [COLOR_W-1:0]  intf_pix_rd_rdata, intf_pix_rd_gdata, intf_pix_rd_bdata;
    logic                VGA_hsync, VGA_vsync;
    logic [OUT_W-1:0]    VGA_red, VGA_green, VGA_blue;
    logic [13:0]         pins;

    mf_disp_intf_vga_scaler #(
        .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
        .SRC_W(SRC_W), .SRC_H(SRC_H), .ADDR_W(ADDR_W),
        .COLOR_W(COLOR_W), .OUT_W(OUT_W), .RD_LAT(RD_LAT)
    ) dut (
        .vga_clk           (vga_clk),
        .resetn            (resetn),
        .intf_mode_enabled (intf_mode_enabled),
        .intf_mode_scale   (intf_mode_scale),
        .intf_mode_test    (intf_mode_test),
        .intf_border_rgb   (intf_border_rgb),
        .intf_frame_switch (intf_frame_switch),
        .intf_frame_sel    (intf_frame_sel),
        .intf_frame_done   (intf_frame_done),
        .intf_pix_rd_vld   (intf_pix_rd_vld),
        .intf_pix_rd_addr  (intf_pix_rd_addr),
        .intf_pix_rd_rdata (intf_pix_rd_rdata),
        .intf_pix_rd_gdata (intf_pix_rd_gdata),
        .intf_pix_rd_bdata (intf_pix_rd_bdata),
        .VGA_hsync         (VGA_hsync),
        .VGA_vsync         (VGA_vsync),
        .VGA_red           (VGA_red),
        .VGA_green         (VGA_green),
        .VGA_blue          (VGA_blue)
    );

    assign pins = {VGA_hsync, VGA_vsync, VGA_red, VGA_green, VGA_blue};

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // Framebuffer content as a function of address: r = addr[5:0].
    function automatic logic [17:0] fb_word(input logic [ADDR_W-1:0] a);
        logic [5:0] r;
        r = a[5:0];
        return {r, r ^ 6'h2A, {r[1:0], r[5:2]}};
    endfunction

    // Framebuffer read port model with RD_LAT cycles of latency.
    logic [ADDR_W-1:0] fb_pipe [RD_LAT];
    always @(posedge vga_clk) begin
        fb_pipe[0] <= intf_pix_rd_addr;
        for (int i = 1; i < RD_LAT; i++) fb_pipe[i] <= fb_pipe[i-1];
    end
    assign {intf_pix_rd_rdata, intf_pix_rd_gdata, intf_pix_rd_bdata} =
        fb_word(fb_pipe[RD_LAT-1]);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------- reference model
    int          mh, mv, msc, mts;
    logic        msel, mpend, mdone;
    logic [13:0] sb [$];

    always @(negedge vga_clk) begin : model
        int          s, sw, sh, xo, yo, sx, sy;
        logic        en, win, act, fe;
        logic [ADDR_W-1:0] a_e;
        logic [17:0] w;
        logic [3:0]  r, g, b;
        logic        hs, vs;

        if (!resetn) begin
            mh = 0; mv = 0; msc = 0; mts = 0;
            msel = 1'b0; mpend = 1'b0; mdone = 1'b0;
            sb.delete();
            check("rst_pins", pins, PINS_IDLE);
            check("rst_sel", intf_frame_sel, 0);
            check("rst_done", intf_frame_done, 0);
            check("rst_vld", intf_pix_rd_vld, 0);
            check("rst_addr", intf_pix_rd_addr, 0);
        end else begin
            en = intf_mode_enabled;
            s  = msc + 1;
            sw = (SRC_W * s < H_ACTIVE) ? SRC_W * s : H_ACTIVE;
            sh = (SRC_H * s < V_ACTIVE) ? SRC_H * s : V_ACTIVE;
            xo = (H_ACTIVE - sw) / 2;
            yo = (V_ACTIVE - sh) / 2;
            win = en && mh >= xo && mh < xo + sw && mv >= yo && mv < yo + sh;
            act = en && mh < H_ACTIVE && mv < V_ACTIVE;
            sx  = win ? (mh - xo) / s : 0;
            sy  = win ? (mv - yo) / s : 0;
            a_e = ADDR_W'(sy * SRC_W + sx);

            check("rd_vld", intf_pix_rd_vld, win && mts == 0);
            if (win && mts == 0) check("rd_addr", intf_pix_rd_addr, a_e);
            check("frame_sel", intf_frame_sel, msel);
            check("frame_done", intf_frame_done, mdone);

            hs = !(en && mh >= H_ACTIVE + H_FRONT && mh < H_ACTIVE + H_FRONT + H_SYNC);
            vs = !(en && mv >= V_ACTIVE + V_FRONT && mv < V_ACTIVE + V_FRONT + V_SYNC);
            r = 4'h0; g = 4'h0; b = 4'h0;
            if (act && !win) begin
                {r, g, b} = intf_border_rgb;
            end else if (win) begin
                case (mts)
                    0: begin
                        w = fb_word(a_e);
                        r = w[17:14]; g = w[11:8]; b = w[5:2];
                    end
                    1: begin
                        if (sy < SRC_H / 3) r = 4'hF;
                        else if (sy < 2 * SRC_H / 3) g = 4'hF;
                        else b = 4'hF;
                    end
                    2: if ((((sx >> 3) ^ (sy >> 3)) & 1) != 0) begin
                        r = 4'hF; g = 4'hF; b = 4'hF;
                    end
                    default: begin r = 4'(sx); g = 4'(sy); end
                endcase
            end
            sb.push_back({hs, vs, r, g, b});
            if (sb.size() == RD_LAT + 2) check("pins", pins, sb.pop_front());

            // Advance to the state seen after the coming edge.
            fe = en && mh == HT - 1 && mv == VT - 1;
            mdone = fe;
            if (!en || fe) begin
                msc = intf_mode_scale;
                mts = intf_mode_test;
            end
            if ((!en || fe) && (mpend || intf_frame_switch)) begin
                msel  = !msel;
                mpend = 1'b0;
            end else if (intf_frame_switch) begin
                mpend = 1'b1;
            end
            if (!en) begin
                mh = 0; mv = 0;
            end else if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    int cur = 0;

    task automatic goto(input int c);
        while (cur < c) begin
            @(posedge vga_clk);
            #1;
            cur++;
        end
    endtask

    initial begin
        resetn            = 1'b0;
        intf_mode_enabled = 1'b0;
        intf_mode_scale   = 2'd0;
        intf_mode_test    = 2'd0;
        intf_border_rgb   = 12'h5A3;
        intf_frame_switch = 1'b0;
        repeat (4) @(posedge vga_clk);
        #1 resetn = 1'b1;
        repeat (3) @(posedge vga_clk);
        #1 intf_mode_enabled = 1'b1;     // cycle 0 of frame 0, scale x1
        cur = 0;

        // Frame 0: mid-frame switch and scale change (take effect at frame end).
        goto(300);      intf_frame_switch = 1'b1; intf_mode_scale = 2'd1;
        goto(301);      intf_frame_switch = 1'b0;
        goto(FT + 1);   check("sel_after_f0", intf_frame_sel, 1);

        // Frame 1: x2; switch coincident with the frame-end cycle.
        goto(FT + 400); intf_mode_scale = 2'd2;
        goto(2*FT - 1); intf_frame_switch = 1'b1;
        goto(2*FT);     intf_frame_switch = 1'b0;
        goto(2*FT + 1); check("sel_after_f1", intf_frame_sel, 0);

        // Frame 2: x3 clipped; request bands at x1 for the next frame.
        goto(2*FT + 300); intf_mode_scale = 2'd0; intf_mode_test = 2'd1;

        // Frame 3: bands; checker requested mid-frame.
        goto(3*FT + 1);   check("sel_no_extra", intf_frame_sel, 0);
        goto(3*FT + 400); intf_mode_test = 2'd2;

        // Frame 4: checker; gradient at x2 next.
        goto(4*FT + 400); intf_mode_test = 2'd3; intf_mode_scale = 2'd1;

        // Frame 5: gradient; framebuffer image at x4 next.
        goto(5*FT + 400); intf_mode_test = 2'd0; intf_mode_scale = 2'd3;

        // Frame 6: x4 image, then disable mid-frame and switch while idle.
        goto(6*FT + 300); intf_mode_enabled = 1'b0;
        goto(6*FT + 305); intf_frame_switch = 1'b1; intf_mode_scale = 2'd0;
        goto(6*FT + 306); intf_frame_switch = 1'b0;
        check("sel_idle_swap", intf_frame_sel, 1);
        goto(6*FT + 330); intf_mode_enabled = 1'b1;

        // Run into the second line-range of a fresh frame, then reset mid-frame.
        goto(7*FT + 380);
        resetn = 1'b0;
        #1 check("rst_now_pins", pins, PINS_IDLE);
        repeat (3) @(posedge vga_clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
